intr_ctrl: RTL and testbench

Interrupt controller that sits directly downstream of the toy IO devices. It collects their latched `intr` lines, masks them, and picks the highest-priority device. It presents one request at a time to the CPU core, then returns a one-cycle `ack` to the serviced device, which clears that device's latch.

---
 rtl/intc_pkg.sv | 16 +
 rtl/intc_prio_enc.sv | 24 ++
 rtl/intr_ctrl.sv | 81 ++++++++
 tb/tb_intr_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2,
    ACK  = 2'd3
  } intc_state_t;

  // Smallest id width that can name every device; never below one bit.
  function automatic int intc_id_w(input int n_dev);
    return (n_dev <= 2) ? 1 : $clog2(n_dev);
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational.
module intc_prio_enc #(
  parameter int N_DEV = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_DEV-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  always_comb begin
    // NOTE: defaults come first so no path leaves id/valid unassigned (no latch).
    id    = '0;
    valid = 1'b0;
    // Walk from the top down so the lowest set index is the last to write.
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: masks device lines, presents one request at a time
// to the CPU and acks the serviced device after end-of-interrupt.
module intr_ctrl
  import intc_pkg::*;
#(
  parameter int               N_DEV    = 2,
  parameter int               ID_W     = intc_id_w(N_DEV),
  parameter logic [N_DEV-1:0] MASK_RST = '1,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_intr,
  output logic [N_DEV-1:0] dev_ack,
  input  logic             mask_we,
  input  logic [N_DEV-1:0] mask_wd,
  output logic [N_DEV-1:0] mask_q,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_take,
  input  logic             eoi,
  output logic             busy,
  output logic [CNT_W-1:0] svc_cnt
);

  intc_state_t      state, state_nxt;
  logic [N_DEV-1:0] eligible;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;

  assign eligible = dev_intr & mask_q;

  intc_prio_enc #(
    .N_DEV (N_DEV),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .id    (win_id),
    .valid (win_vld)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (win_vld) state_nxt = REQ;
      // Take beats a coincident mask clear; withdrawal looks at the mask register.
      REQ: begin
        if (irq_take)            state_nxt = SERV;
        else if (!mask_q[irq_id]) state_nxt = IDLE;
      end
      SERV: if (eoi) state_nxt = ACK;
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    if (!rst) begin
      state   <= IDLE;
      irq_id  <= '0;
      mask_q  <= MASK_RST;
      svc_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (mask_we) mask_q <= mask_wd;
      if (state == IDLE && win_vld) irq_id <= win_id;
      if (state == ACK) svc_cnt <= svc_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    dev_ack = '0;
    if (state == ACK) dev_ack[irq_id] = 1'b1;
  end

  assign irq  = (state == REQ);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with a two-device latch model and a 2-bit counter.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dev_intr = 2'b00;
  logic [1:0] dev_ack;
  logic       mask_we;
  logic [1:0] mask_wd;
  logic [1:0] mask_q;
  logic       irq;
  logic [0:0] irq_id;
  logic       irq_take;
  logic       eoi;
  logic       busy;
  logic [1:0] svc_cnt;
  logic [1:0] raise;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  intr_ctrl #(
    .N_DEV    (2),
    .ID_W     (1),
    .MASK_RST (2'b11),
    .CNT_W    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dev_intr (dev_intr),
    .dev_ack  (dev_ack),
    .mask_we  (mask_we),
    .mask_wd  (mask_wd),
    .mask_q   (mask_q),
    .irq      (irq),
    .irq_id   (irq_id),
    .irq_take (irq_take),
    .eoi      (eoi),
    .busy     (busy),
    .svc_cnt  (svc_cnt)
  );

  // Device latches: set by raise, cleared by ack; ack dominates. Not reset by rst.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dev_ack[i])    dev_intr[i] <= 1'b0;
      else if (raise[i]) dev_intr[i] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the DUT is in REQ for exp_id; runs take, eoi, ack and returns in IDLE.
  task automatic serve(input string tag, input logic exp_id);
    check({tag, " req irq"}, 32'(irq), 32'd1);
    check({tag, " req id"}, 32'(irq_id), 32'(exp_id));
    irq_take = 1'b1;
    tick();
    irq_take = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check({tag, " ack"}, 32'(dev_ack), exp_id ? 32'd2 : 32'd1);
    tick();
    exp_cnt++;
    check({tag, " cnt"}, 32'(svc_cnt), 32'(exp_cnt % 4));
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; raise = 2'b11; mask_we = 1'b0; mask_wd = 2'b00;
    irq_take = 1'b0; eoi = 1'b0;

    // Reset held three edges with both lines pending.
    tick();
    raise = 2'b00;
    tick();
    tick();
    check("rst irq", 32'(irq), 32'd0);
    check("rst id", 32'(irq_id), 32'd0);
    check("rst ack", 32'(dev_ack), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst mask", 32'(mask_q), 32'd3);
    check("rst cnt", 32'(svc_cnt), 32'd0);
    rst = 1'b1;
    tick();
    check("post rst irq", 32'(irq), 32'd1);
    check("post rst id", 32'(irq_id), 32'd0);

    // Priority: device 0 first, device 1 requests two cycles after its ack.
    serve("prio d0", 1'b0);
    tick();
    check("prio d1 irq", 32'(irq), 32'd1);
    check("prio d1 id", 32'(irq_id), 32'd1);

    // Single service of device 1 with take one cycle late, eoi two cycles later.
    tick();
    check("single hold irq", 32'(irq), 32'd1);
    check("single hold id", 32'(irq_id), 32'd1);
    irq_take = 1'b1;
    tick();
    irq_take = 1'b0;
    check("single serv irq", 32'(irq), 32'd0);
    check("single serv busy", 32'(busy), 32'd1);
    tick();
    check("single serv wait", 32'(busy), 32'd1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("single ack", 32'(dev_ack), 32'd2);
    tick();
    exp_cnt++;
    check("single ack gone", 32'(dev_ack), 32'd0);
    check("single cnt", 32'(svc_cnt), 32'(exp_cnt % 4));
    check("single busy", 32'(busy), 32'd0);

    // Stray eoi in IDLE.
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("idle eoi busy", 32'(busy), 32'd0);
    check("idle eoi ack", 32'(dev_ack), 32'd0);
    check("idle eoi cnt", 32'(svc_cnt), 32'(exp_cnt % 4));

    // Mask withdraw of a pending device-1 request.
    raise = 2'b10;
    tick();
    raise = 2'b00;
    tick();
    check("wd req id", 32'(irq_id), 32'd1);
    mask_we = 1'b1; mask_wd = 2'b01;
    tick();
    mask_we = 1'b0;
    check("wd mask", 32'(mask_q), 32'd1);
    check("wd still req", 32'(irq), 32'd1);
    tick();
    check("wd irq", 32'(irq), 32'd0);
    check("wd busy", 32'(busy), 32'd0);
    check("wd ack", 32'(dev_ack), 32'd0);
    tick();
    check("wd stays idle", 32'(busy), 32'd0);
    mask_we = 1'b1; mask_wd = 2'b11;
    tick();
    mask_we = 1'b0;
    check("unmask idle", 32'(busy), 32'd0);
    tick();
    check("unmask irq", 32'(irq), 32'd1);
    check("unmask id", 32'(irq_id), 32'd1);

    // Higher-priority arrival does not preempt; stray eoi in REQ is ignored.
    raise = 2'b01;
    tick();
    raise = 2'b00;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("no preempt id", 32'(irq_id), 32'd1);
    check("req eoi irq", 32'(irq), 32'd1);
    check("req eoi ack", 32'(dev_ack), 32'd0);
    check("req eoi cnt", 32'(svc_cnt), 32'(exp_cnt % 4));

    // Take coinciding with a mask clear: take wins; masking in SERV is harmless.
    irq_take = 1'b1; mask_we = 1'b1; mask_wd = 2'b01;
    tick();
    irq_take = 1'b0; mask_we = 1'b0;
    check("take+mask busy", 32'(busy), 32'd1);
    check("take+mask irq", 32'(irq), 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("take+mask ack", 32'(dev_ack), 32'd2);
    tick();
    exp_cnt++;
    check("take+mask cnt", 32'(svc_cnt), 32'(exp_cnt % 4));
    tick();
    check("d0 pending irq", 32'(irq), 32'd1);
    check("d0 pending id", 32'(irq_id), 32'd0);

    // Reset in SERV: no ack, counter and mask restored, line re-served.
    irq_take = 1'b1;
    tick();
    irq_take = 1'b0;
    check("pre rst serv", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_cnt = 0;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst ack", 32'(dev_ack), 32'd0);
    check("mid rst cnt", 32'(svc_cnt), 32'd0);
    check("mid rst mask", 32'(mask_q), 32'd3);
    tick();

    // Five services with a 2-bit counter wrap to 1.
    serve("wrap 1", 1'b0);
    for (int k = 2; k <= 5; k++) begin
      raise = 2'b01;
      tick();
      raise = 2'b00;
      tick();
      serve($sformatf("wrap %0d", k), 1'b0);
    end
    check("wrap final", 32'(svc_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
